// File: rtl/spi_cmd_pkg.sv
// Shared header layout, state encoding and error codes for the SPI frame sequencer.
// Optional error counter is enabled by SPI_CMD_ERR_CNT_EN (see spi_slave_cmd_ctrl).
package spi_cmd_pkg;

    localparam int ADDR_LSB = 0;
    localparam int LEN_LSB  = 8;
    localparam int RW_BIT   = 15;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_NEXT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_WR      = S_WR,
        ST_RD_REQ  = S_RD_REQ,
        ST_RD_WAIT = S_RD_WAIT,
        ST_RD_NEXT = S_RD_NEXT,
        ST_DONE    = S_DONE
    } state_t;

    localparam logic [1:0] ERR_ABORT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    // Field positions scale with the configured widths; the constants above are the 16-bit defaults.
    function automatic int len_lsb(input int addr_w);
        return ADDR_LSB + addr_w;
    endfunction

    function automatic int rw_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/spi_mcs_sync.sv
// Two-flop synchroniser for SPI chip select with active level and
// active-to-inactive edge detection.
module spi_mcs_sync #(
    parameter bit MCS_VALID_LEVEL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_mcs,
    output logic o_active,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic       r_prev_active;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync        <= {2{~MCS_VALID_LEVEL}};
            r_prev_active <= 1'b0;
        end else begin
            r_sync        <= {r_sync[0], i_mcs};
            r_prev_active <= o_active;
        end
    end

    assign o_active = (r_sync[1] == MCS_VALID_LEVEL);
    assign o_fall   = r_prev_active & ~o_active;

endmodule

// File: rtl/spi_slave_cmd_ctrl.sv
// Frame sequencer: SPI header + data words -> register-bank writes / read fetches.
// Define SPI_CMD_ERR_CNT_EN to add the saturating o_err_cnt output.
module spi_slave_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter bit MCS_VALID_LEVEL = 1'b0,
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 8,
    parameter int LEN_W           = 7,
    parameter int RD_TIMEOUT      = 255
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              mcs,
    input  logic              i_rx_evt,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_tx_evt,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_frame_done,
    output logic              o_err,
    output logic [1:0]        o_err_code
`ifdef SPI_CMD_ERR_CNT_EN
    ,
    output logic [15:0]       o_err_cnt
`endif
);

    localparam int LEN_LO = len_lsb(ADDR_W);
    localparam int RW     = rw_bit(DATA_W);
    localparam int REM_W  = LEN_W + 1;
    localparam int TMO_W  = $clog2(RD_TIMEOUT + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_remain;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_active;
    logic              w_fall;
    logic              w_inactive;
    logic [ADDR_W-1:0] w_hdr_addr;
    logic [LEN_W-1:0]  w_hdr_len;
    logic              w_hdr_rw;

    spi_mcs_sync #(
        .MCS_VALID_LEVEL(MCS_VALID_LEVEL)
    ) u_mcs_sync (
        .i_clk    (user_clk),
        .i_rst    (user_rst),
        .i_mcs    (mcs),
        .o_active (w_active),
        .o_fall   (w_fall)
    );

    assign w_inactive = ~w_active | w_fall;
    assign w_hdr_addr = i_rx_data[ADDR_LSB +: ADDR_W];
    assign w_hdr_len  = i_rx_data[LEN_LO +: LEN_W];
    assign w_hdr_rw   = i_rx_data[RW];

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_remain     <= '0;
            r_tmo        <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_rd_req     <= 1'b0;
            o_rd_addr    <= '0;
            o_tx_evt     <= 1'b0;
            o_tx_data    <= '0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= '0;
        end else begin
            o_wr_en      <= 1'b0;
            o_tx_evt     <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_rx_evt && w_active) begin
                        r_addr   <= w_hdr_addr;
                        r_remain <= REM_W'(w_hdr_len) + REM_ONE;
                        r_state  <= w_hdr_rw ? ST_WR : ST_RD_REQ;
                    end
                end
                ST_WR: begin
                    // A word arriving with deselect is still written; abort waits a cycle.
                    if (i_rx_evt) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= r_addr;
                        o_wr_data <= i_rx_data;
                        r_addr    <= r_addr + 1'b1;
                        r_remain  <= r_remain - REM_ONE;
                        if (r_remain == REM_ONE)
                            r_state <= ST_DONE;
                    end else if (w_inactive) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_ABORT;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (w_inactive) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_ABORT;
                        r_state    <= ST_IDLE;
                    end else begin
                        o_rd_req  <= 1'b1;
                        o_rd_addr <= r_addr;
                        r_tmo     <= '0;
                        r_state   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_inactive) begin
                        o_rd_req   <= 1'b0;
                        o_err      <= 1'b1;
                        o_err_code <= ERR_ABORT;
                        r_state    <= ST_IDLE;
                    end else if (i_rd_ack) begin
                        o_rd_req  <= 1'b0;
                        o_tx_evt  <= 1'b1;
                        o_tx_data <= i_rd_data;
                        r_addr    <= r_addr + 1'b1;
                        r_remain  <= r_remain - REM_ONE;
                        r_state   <= (r_remain == REM_ONE) ? ST_DONE
                                                           : ST_RD_NEXT;
                    end else if (r_tmo == TMO_LAST) begin
                        o_rd_req   <= 1'b0;
                        o_tx_data  <= '0;
                        o_err      <= 1'b1;
                        o_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_RD_NEXT: begin
                    if (i_rx_evt) begin
                        r_state <= ST_RD_REQ;
                    end else if (w_inactive) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_ABORT;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (i_rx_evt) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_OVERRUN;
                    end else if (w_inactive) begin
                        o_frame_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_CMD_ERR_CNT_EN
    always_ff @(posedge user_clk) begin
        if (user_rst)
            o_err_cnt <= '0;
        else if (o_err && o_err_cnt != 16'hFFFF)
            o_err_cnt <= o_err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Directed bench for spi_slave_cmd_ctrl: write/read bursts, wrap,
// timeout, abort, overrun and mid-operation reset.
module tb_spi_slave_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mcs;
    logic        rx_evt;
    logic [15:0] rx_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        tx_evt;
    logic [15:0] tx_data;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_code;
`ifdef SPI_CMD_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    always #5 clk = ~clk;

    spi_slave_cmd_ctrl dut (
        .user_clk     (clk),
        .user_rst     (rst),
        .mcs          (mcs),
        .i_rx_evt     (rx_evt),
        .i_rx_data    (rx_data),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_rd_req     (rd_req),
        .o_rd_addr    (rd_addr),
        .i_rd_ack     (rd_ack),
        .i_rd_data    (rd_data),
        .o_tx_evt     (tx_evt),
        .o_tx_data    (tx_data),
        .o_frame_done (frame_done),
        .o_err        (err),
        .o_err_code   (err_code)
`ifdef SPI_CMD_ERR_CNT_EN
        ,
        .o_err_cnt    (err_cnt)
`endif
    );

    int n_tot = 0;
    int n_bad = 0;

    logic [7:0]  qa[$];
    logic [15:0] qd[$];
    logic [15:0] qt[$];
    logic [7:0]  qr[$];
    logic [1:0]  qe[$];
    int          n_done = 0;
    logic        req_d = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                qa.push_back(wr_addr);
                qd.push_back(wr_data);
            end
            if (tx_evt) qt.push_back(tx_data);
            if (rd_req && !req_d) qr.push_back(rd_addr);
            if (frame_done) n_done++;
            if (err) qe.push_back(err_code);
        end
        req_d = rd_req;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        qa.delete();
        qd.delete();
        qt.delete();
        qr.delete();
        qe.delete();
        n_done = 0;
    endtask

    task automatic mcs_on();
        mcs = 1'b0;
        repeat (3) tick();
    endtask

    task automatic mcs_off();
        mcs = 1'b1;
        repeat (6) tick();
    endtask

    task automatic send(input logic [15:0] w);
        rx_data = w;
        rx_evt  = 1'b1;
        tick();
        rx_evt  = 1'b0;
    endtask

    task automatic wait_req(input int limit);
        int n = 0;
        while (!rd_req && n < limit) begin
            tick();
            n++;
        end
        check("req_seen", 32'(rd_req), 32'd1);
    endtask

    task automatic ack(input logic [15:0] d);
        rd_data = d;
        rd_ack  = 1'b1;
        tick();
        rd_ack  = 1'b0;
        check("ack_tx_evt", 32'(tx_evt), 32'd1);
        check("ack_req_drop", 32'(rd_req), 32'd0);
        check("ack_tx_data", 32'(tx_data), 32'(d));
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        mcs     = 1'b1;
        rx_evt  = 1'b0;
        rx_data = '0;
        rd_ack  = 1'b0;
        rd_data = '0;
        repeat (3) tick();
        check("rst_outs", {wr_en, rd_req, tx_evt, frame_done, err,
                           err_code}, 32'd0);
        check("rst_data", {wr_data, tx_data}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // 1: write burst of 3
        clear();
        mcs_on();
        send(16'h8210);
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        check("wr_lat", 32'(wr_en), 32'd1);
        check("wr_lat_data", 32'(wr_data), 32'h3333);
        mcs_off();
        check("wr_cnt", qa.size(), 3);
        check("wr_a0", 32'(qa[0]), 32'h10);
        check("wr_a1", 32'(qa[1]), 32'h11);
        check("wr_a2", 32'(qa[2]), 32'h12);
        check("wr_d0", 32'(qd[0]), 32'h1111);
        check("wr_d1", 32'(qd[1]), 32'h2222);
        check("wr_d2", 32'(qd[2]), 32'h3333);
        check("wr_done", n_done, 1);
        check("wr_noerr", qe.size(), 0);

        // 2: address wrap
        clear();
        mcs_on();
        send(16'h81FF);
        send(16'hAAAA);
        send(16'h5555);
        mcs_off();
        check("wrap_cnt", qa.size(), 2);
        check("wrap_a0", 32'(qa[0]), 32'hFF);
        check("wrap_a1", 32'(qa[1]), 32'h00);
        check("wrap_d1", 32'(qd[1]), 32'h5555);
        check("wrap_done", n_done, 1);

        // 3: read burst of 2
        clear();
        mcs_on();
        send(16'h0120);
        wait_req(20);
        check("rd_addr0", 32'(rd_addr), 32'h20);
        repeat (3) tick();
        ack(16'hABCD);
        send(16'hFFFF);
        wait_req(20);
        check("rd_addr1", 32'(rd_addr), 32'h21);
        ack(16'h1234);
        mcs_off();
        check("rd_tx_cnt", qt.size(), 2);
        check("rd_tx0", 32'(qt[0]), 32'hABCD);
        check("rd_tx1", 32'(qt[1]), 32'h1234);
        check("rd_req_cnt", qr.size(), 2);
        check("rd_done", n_done, 1);
        check("rd_noerr", qe.size(), 0);
        check("rd_nowr", qa.size(), 0);

        // 4: read timeout
        clear();
        mcs_on();
        send(16'h0005);
        wait_req(20);
        check("tmo_addr", 32'(rd_addr), 32'h05);
        n = 0;
        while (rd_req && n < 400) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 255);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_code", 32'(err_code), 32'd2);
        check("tmo_tx0", 32'(tx_data), 32'd0);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        mcs_off();
        check("tmo_no_tx", qt.size(), 0);
        check("tmo_errs", qe.size(), 1);
        check("tmo_done", n_done, 1);

        // 5a: abort mid write
        clear();
        mcs_on();
        send(16'h8300);
        send(16'h0BAD);
        mcs_off();
        check("abt_wr", qa.size(), 1);
        check("abt_errs", qe.size(), 1);
        check("abt_code", 32'(qe[0]), 32'd1);
        check("abt_nodone", n_done, 0);

        // 5b: overrun
        clear();
        mcs_on();
        send(16'h8000);
        send(16'h7777);
        send(16'h8888);
        tick();
        check("ovr_wr", qa.size(), 1);
        check("ovr_d0", 32'(qd[0]), 32'h7777);
        check("ovr_errs", qe.size(), 1);
        check("ovr_code", 32'(qe[0]), 32'd3);
        mcs_off();
        check("ovr_done", n_done, 1);
`ifdef SPI_CMD_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'd3);
`endif

        // 6: reset while read request is pending
        clear();
        mcs_on();
        send(16'h0040);
        wait_req(20);
        check("mid_req", 32'(rd_addr), 32'h40);
        rst = 1'b1;
        tick();
        check("mid_rst_req", {rd_req, rd_addr}, 32'd0);
        check("mid_rst_pulses", {wr_en, tx_evt, frame_done, err,
                                 err_code}, 32'd0);
        check("mid_rst_data", {wr_addr, wr_data}, 32'd0);
`ifdef SPI_CMD_ERR_CNT_EN
        check("mid_rst_cnt", 32'(err_cnt), 32'd0);
`endif
        tick();
        rst = 1'b0;
        mcs_off();
        check("mid_no_done", n_done, 0);
        check("mid_no_err", qe.size(), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
